// File: rtl/pong_pkg.sv
// Shared playfield geometry and paddle FSM encoding for the pong blocks.
package pong_pkg;

  localparam int unsigned COORD_W = 16;

  localparam logic [COORD_W-1:0] X_MIN    = 16'd144;
  localparam logic [COORD_W-1:0] X_MAX    = 16'd783;
  localparam logic [COORD_W-1:0] PAD_W    = 16'd80;
  localparam logic [COORD_W-1:0] CENTRE_L = 16'd424;
  localparam logic [COORD_W-1:0] CENTRE_R = 16'd503;

  typedef enum logic {
    PLAY   = 1'b0,
    FREEZE = 1'b1
  } pad_state_e;

  function automatic logic [COORD_W-1:0] min_coord(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counter that accepts a new level
// only after DB_CYCLES consecutive differing samples.
module btn_debounce
  import pong_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  logic               sync1;
  logic               sync2;
  logic [COORD_W-1:0] cnt;
  logic [COORD_W:0]   cnt_inc_c;

  assign cnt_inc_c = {1'b0, cnt} + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // Any sample matching the accepted level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt_inc_c >= {1'b0, DB_CYCLES}) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt_inc_c[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: debounced buttons move both paddles at a
// divided rate, clamped to the field; a ball loss recentres and freezes play.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES    = 16'd50000,
  parameter logic [15:0] STEP_DIV     = 16'd4,
  parameter logic [15:0] STEP_PX      = 16'd2,
  parameter logic [15:0] FREEZE_TICKS = 16'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_l1,
  input  logic        btn_r1,
  input  logic        btn_l2,
  input  logic        btn_r2,
  input  logic        fell,
  output logic [15:0] left_r1,
  output logic [15:0] right_r1,
  output logic [15:0] left_r2,
  output logic [15:0] right_r2,
  output logic        frozen
);

  logic db_l1, db_r1, db_l2, db_r2;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l1 (.clk(clk), .rst_n(rst_n), .btn(btn_l1), .level(db_l1));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r1 (.clk(clk), .rst_n(rst_n), .btn(btn_r1), .level(db_r1));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l2 (.clk(clk), .rst_n(rst_n), .btn(btn_l2), .level(db_l2));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r2 (.clk(clk), .rst_n(rst_n), .btn(btn_r2), .level(db_r2));

  logic [COORD_W-1:0] divider;
  logic               tick_c;
  logic [COORD_W-1:0] frz_load_c;

  pad_state_e         state, state_nxt;
  logic [COORD_W-1:0] frz_cnt, frz_cnt_nxt;
  logic [COORD_W-1:0] l1_nxt, r1_nxt, l2_nxt, r2_nxt;
  logic               frozen_nxt;

  assign tick_c     = (divider == STEP_DIV - 16'd1);
  assign frz_load_c = (FREEZE_TICKS == 16'd0) ? 16'd1 : FREEZE_TICKS;

  // One clamped step of a paddle; returns {left, right}. Both or neither held means hold.
  function automatic logic [2*COORD_W-1:0] move_pad(input logic [COORD_W-1:0] left,
                                                    input logic [COORD_W-1:0] right,
                                                    input logic go_l,
                                                    input logic go_r);
    logic [COORD_W-1:0] d;
    d        = '0;
    move_pad = {left, right};
    if (go_l && !go_r) begin
      d        = min_coord(STEP_PX, left - X_MIN);
      move_pad = {left - d, right - d};
    end else if (go_r && !go_l) begin
      d        = min_coord(STEP_PX, X_MAX - right);
      move_pad = {left + d, right + d};
    end
  endfunction

  always_comb begin
    state_nxt   = state;
    frz_cnt_nxt = frz_cnt;
    frozen_nxt  = frozen;
    l1_nxt      = left_r1;
    r1_nxt      = right_r1;
    l2_nxt      = left_r2;
    r2_nxt      = right_r2;
    if (fell) begin
      // A ball loss outranks any tick, in either state.
      state_nxt   = FREEZE;
      frz_cnt_nxt = frz_load_c;
      frozen_nxt  = 1'b1;
      l1_nxt      = CENTRE_L;
      r1_nxt      = CENTRE_R;
      l2_nxt      = CENTRE_L;
      r2_nxt      = CENTRE_R;
    end else begin
      case (state)
        PLAY: begin
          if (tick_c) begin
            {l1_nxt, r1_nxt} = move_pad(left_r1, right_r1, db_l1, db_r1);
            {l2_nxt, r2_nxt} = move_pad(left_r2, right_r2, db_l2, db_r2);
          end
        end
        FREEZE: begin
          l1_nxt = CENTRE_L;
          r1_nxt = CENTRE_R;
          l2_nxt = CENTRE_L;
          r2_nxt = CENTRE_R;
          if (tick_c) begin
            if (frz_cnt <= 16'd1) begin
              state_nxt   = PLAY;
              frz_cnt_nxt = '0;
              frozen_nxt  = 1'b0;
            end else begin
              frz_cnt_nxt = frz_cnt - 16'd1;
            end
          end
        end
        default: state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PLAY;
      frz_cnt  <= '0;
      frozen   <= 1'b0;
      divider  <= '0;
      left_r1  <= CENTRE_L;
      right_r1 <= CENTRE_R;
      left_r2  <= CENTRE_L;
      right_r2 <= CENTRE_R;
    end else begin
      state    <= state_nxt;
      frz_cnt  <= frz_cnt_nxt;
      frozen   <= frozen_nxt;
      divider  <= tick_c ? 16'd0 : divider + 16'd1;
      left_r1  <= l1_nxt;
      right_r1 <= r1_nxt;
      left_r2  <= l2_nxt;
      right_r2 <= r2_nxt;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: vector table plus clamp, glitch and reset sequences.
module tb_paddle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        btn_l1, btn_r1, btn_l2, btn_r2, fell;
  logic [15:0] left_r1, right_r1, left_r2, right_r2;
  logic        frozen;
  logic [15:0] b_left_r1, b_right_r1, b_left_r2, b_right_r2;
  logic        b_frozen;

  int errors = 0;
  int checks = 0;

  paddle_ctrl #(
    .DB_CYCLES(16'd4), .STEP_DIV(16'd4), .STEP_PX(16'd2), .FREEZE_TICKS(16'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_l1(btn_l1), .btn_r1(btn_r1), .btn_l2(btn_l2), .btn_r2(btn_r2), .fell(fell),
    .left_r1(left_r1), .right_r1(right_r1), .left_r2(left_r2), .right_r2(right_r2),
    .frozen(frozen)
  );

  // Same stimulus with a 3-pixel step so the paddles land one pixel off each wall.
  paddle_ctrl #(
    .DB_CYCLES(16'd4), .STEP_DIV(16'd4), .STEP_PX(16'd3), .FREEZE_TICKS(16'd3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .btn_l1(btn_l1), .btn_r1(btn_r1), .btn_l2(btn_l2), .btn_r2(btn_r2), .fell(fell),
    .left_r1(b_left_r1), .right_r1(b_right_r1), .left_r2(b_left_r2), .right_r2(b_right_r2),
    .frozen(b_frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        l1, r1, l2, r2, fl;
    int unsigned n;
    logic [15:0] e1, e2;
    logic        ef;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just before edge E1, with the divider at 0.
  task automatic reset_dut();
    rst_n  = 1'b0;
    btn_l1 = 1'b0; btn_r1 = 1'b0; btn_l2 = 1'b0; btn_r2 = 1'b0; fell = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                         input logic ef);
    chk({tag, " left_r1"},  left_r1,  e1);
    chk({tag, " right_r1"}, right_r1, e1 + 16'd79);
    chk({tag, " left_r2"},  left_r2,  e2);
    chk({tag, " right_r2"}, right_r2, e2 + 16'd79);
    chk({tag, " frozen"},   16'(frozen), 16'(ef));
  endtask

  initial begin
    // Ticks land on edges E4, E8, ... counted from reset release.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  16'd424, 16'd424, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6,  16'd424, 16'd424, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  16'd426, 16'd424, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  16'd428, 16'd424, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4,  16'd430, 16'd424, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8,  16'd434, 16'd424, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,  16'd436, 16'd424, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1,  16'd424, 16'd424, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10, 16'd424, 16'd424, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1,  16'd424, 16'd424, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4,  16'd426, 16'd426, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3,  16'd426, 16'd426, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1,  16'd424, 16'd424, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4,  16'd424, 16'd424, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1,  16'd424, 16'd424, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7,  16'd424, 16'd424, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4,  16'd424, 16'd424, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4,  16'd426, 16'd426, 1'b0};

    rst_n  = 1'b0;
    btn_l1 = 1'b0; btn_r1 = 1'b0; btn_l2 = 1'b0; btn_r2 = 1'b0; fell = 1'b0;
    step(2);
    chk_all("reset", 16'd424, 16'd424, 1'b0);
    step(1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      btn_l1 = vecs[i].l1; btn_r1 = vecs[i].r1;
      btn_l2 = vecs[i].l2; btn_r2 = vecs[i].r2;
      fell   = vecs[i].fl;
      step(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ef);
    end

    // Asynchronous reset between clock edges with paddles off centre.
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 16'd424, 16'd424, 1'b0);

    // Reset while frozen must drop back to PLAY.
    btn_r1 = 1'b0; btn_r2 = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    fell = 1'b1;
    step(1);
    fell = 1'b0;
    chk("frz_before_rst", 16'(frozen), 16'd1);
    #3 rst_n = 1'b0;
    #1 chk("frz_async_rst", 16'(frozen), 16'd0);
    step(1);
    rst_n  = 1'b1;
    btn_r1 = 1'b1;
    step(12);
    chk("play_after_rst left_r1", left_r1, 16'd428);

    // Drive paddle 1 into the left wall and paddle 2 into the right wall.
    reset_dut();
    btn_l1 = 1'b1;
    btn_r2 = 1'b1;
    step(4);
    for (int k = 0; k < 145; k++) begin
      int e1, e2, b1, b2;
      step(4);
      e1 = (422 - 2*k < 144) ? 144 : 422 - 2*k;
      e2 = (426 + 2*k > 704) ? 704 : 426 + 2*k;
      b1 = (421 - 3*k < 144) ? 144 : 421 - 3*k;
      b2 = (427 + 3*k > 704) ? 704 : 427 + 3*k;
      chk($sformatf("clamp%0d left_r1", k),    left_r1,    16'(e1));
      chk($sformatf("clamp%0d right_r1", k),   right_r1,   16'(e1 + 79));
      chk($sformatf("clamp%0d right_r2", k),   right_r2,   16'(e2 + 79));
      chk($sformatf("clamp%0d px3 left_r1", k), b_left_r1,  16'(b1));
      chk($sformatf("clamp%0d px3 left_r2", k), b_left_r2,  16'(b2));
    end

    // Glitch shorter than the debounce window must not move paddle 2.
    reset_dut();
    btn_r2 = 1'b1;
    step(3);
    btn_r2 = 1'b0;
    step(13);
    chk("glitch left_r2",  left_r2,  16'd424);
    chk("glitch right_r2", right_r2, 16'd503);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Generates the horizontal extents of both paddles from four raw push-buttons and feeds them to the ball engine (left_r1/right_r1 for the top paddle, left_r2/right_r2 for the bottom paddle). It synchronises and debounces each button, moves each paddle at a fixed divided rate, and clamps the paddles to the visible field. On a ball-fell pulse from the ball engine it recentres both paddles and freezes movement for a serve interval.

Parameters:
DB_CYCLES, 16'd50000, consecutive equal synchronised samples needed to accept a new button level
STEP_DIV, 16'd4, clk cycles per movement tick (tick when divider == STEP_DIV-1)
STEP_PX, 16'd2, pixels moved per tick
FREEZE_TICKS, 16'd500, movement ticks frozen after fell
PAD_W, 16'd80, paddle width in pixels (right = left + PAD_W - 1)
X_MIN, 16'd144, leftmost legal paddle column
X_MAX, 16'd783, rightmost legal paddle column

Ports:
clk  in  1  game clock, the same clock as the ball engine
rst_n  in  1  asynchronous, active-low reset
btn_l1  in  1  raw, asynchronous button: paddle 1 move left
btn_r1  in  1  raw button: paddle 1 move right
btn_l2  in  1  raw button: paddle 2 move left
btn_r2  in  1  raw button: paddle 2 move right
fell  in  1  one-cycle pulse from the ball engine: ball lost
left_r1  out  16  paddle 1 left column
right_r1  out  16  paddle 1 right column
left_r2  out  16  paddle 2 left column
right_r2  out  16  paddle 2 right column
frozen  out  1  high while the FREEZE state is active

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n); every register clears on its assertion, independent of clk.
- Reset values:
  - left_r1 = left_r2 = 424; right_r1 = right_r2 = 503 (centred).
  - frozen = 0; state = PLAY; divider = 0; freeze counter = 0.
  - Debounced levels = 0; synchroniser flops = 0.
- Button path, per button:
  - 2-flop synchroniser, then debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive samples that differ from the current debounced level. Any matching sample resets the counter.
  - Total latency from a clean button edge to the debounced edge is 2 + DB_CYCLES cycles.
- Divider:
  - Free-running 0..STEP_DIV-1; wraps to 0.
  - tick = (divider == STEP_DIV-1), one cycle wide.
  - The divider runs in both states.
- Move request per paddle:
  - left only (debounced L=1, R=0) → move left.
  - right only → move right.
  - both or neither → hold.
- Movement occurs only on a tick in PLAY. Compute in 16-bit unsigned with no wrap:
  - Left move: d = min(STEP_PX, left - X_MIN); left -= d; right -= d.
  - Right move: d = min(STEP_PX, X_MAX - right); left += d; right += d.
  - The invariant right - left == PAD_W - 1 always holds.
  - A paddle at a wall stays put (d = 0).
- FSM:
  - PLAY: on fell → FREEZE.
    - Same cycle: both paddles load their centred values.
    - freeze counter ← FREEZE_TICKS; frozen ← 1 (registered, visible the next cycle).
  - FREEZE:
    - Paddles held at centre and button requests ignored; debouncers keep tracking.
    - Each tick decrements the counter.
    - When a tick arrives with counter == 1 → PLAY and frozen ← 0.
    - FREEZE_TICKS = 0 is treated as 1.
  - fell during FREEZE: recentre again and reload the counter to FREEZE_TICKS.
- Simultaneous events:
  - fell and a movement tick in the same cycle: fell wins and no move is applied.
  - Both paddles may move in the same tick, independently.
- Outputs are registered; a move is visible the cycle after its tick.
- Reset mid-FREEZE returns to PLAY with paddles centred.

Decomposition:
- Shared package pong_pkg holds:
  - X_MIN, X_MAX, PAD_W and the centred reset columns (424/503). These are shared with the ball engine's wall checks (143/784) and the VGA renderer.
  - The state encoding: PLAY = 1'b0, FREEZE = 1'b1.
- One sub-module, btn_debounce (synchroniser + debounce counter; parameter DB_CYCLES), instantiated 4×.
- Divider, FSM, and position arithmetic live in paddle_ctrl.

Test Plan (bench params: DB_CYCLES=4, STEP_DIV=4, STEP_PX=2, FREEZE_TICKS=3):
- Reset → left_r1=424, right_r1=503, left_r2=424, right_r2=503, frozen=0. Assert rst_n low mid-run without a clk edge → outputs return to these values immediately.
- btn_r1 held high → debounced after 6 cycles; each later tick adds 2: 424→426→428… and right_r1 tracks at +79. btn_r2 idle, so paddle 2 is unchanged.
- btn_l1 held until clamp → left_r1 steps 424…146,144, then holds at 144 (right_r1=223). Start at left=145 → d=1, reaching 144 with no underflow.
- btn_l2 and btn_r2 both held → paddle 2 holds. A 3-cycle glitch on btn_r2 (shorter than DB_CYCLES) → no movement.
- fell pulse with paddle 1 at 600/679 → the next cycle shows 424/503 and frozen=1; buttons are ignored for 3 ticks; frozen=0 after the third tick; movement resumes on the following tick.
- fell on the same cycle as a tick, and fell again during FREEZE → no move; the freeze counter reloads to 3 (frozen stays high for 3 further ticks).
